reel_controller: RTL and testbench

REEL_CONTROLLER -- requirements
Module: reel_controller

---
 rtl/reel_controller.sv | 171 +++++++++++++++++
 tb/tb_reel_controller.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reel_controller.sv
//------------------------------------------------------------------------------
// Module      : reel_controller
// Description : Fishing-reel mini-game controller. A one-hot indicator is
//               pulled toward the MSB or drifts toward the LSB on step ticks
//               while a 3-digit BCD countdown runs. The fish is landed after
//               HOLD_STEPS consecutive in-zone steps, and lost on touching a
//               lose bound or when the countdown reaches 000.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module reel_controller #(
    parameter int HOLD_STEPS = 8,   // consecutive in-zone steps to land (1..15)
    parameter int START_POS  = 12   // indicator bit loaded on start (0..25)
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic        pull,
    input  logic        stepTick,
    input  logic        timeTick,
    input  logic [11:0] reelTime,
    input  logic [25:0] leftLoseBound,
    input  logic [25:0] rightLoseBound,
    input  logic [25:0] winZone,
    output logic [25:0] position,
    output logic [11:0] timeLeft,
    output logic        busy,
    output logic        win,
    output logic        lose,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REEL = 2'd1,
        S_WON  = 2'd2,
        S_LOST = 2'd3
    } state_t;

    localparam logic [4:0]  HOLD_LIMIT = 5'(HOLD_STEPS);
    localparam logic [25:0] START_ONEHOT = 26'd1 << START_POS;

    state_t      state_q;
    logic [25:0] position_q;
    logic [11:0] timeLeft_q;
    logic [4:0]  hold_q;
    logic        busy_q;
    logic        win_q;
    logic        lose_q;
    logic        done_q;

    logic [25:0] position_d;
    logic [4:0]  hold_d;
    logic [11:0] timeDec_d;
    logic [11:0] timeLoad_d;
    logic        boundHit;
    logic        holdMet;
    logic        timedOut;

    // Next indicator position for a step tick, saturating at both ends,
    // and the hold count that goes with it.
    always_comb begin
        position_d = position_q;
        if (pull) begin
            if (!position_q[25]) position_d = position_q << 1;
        end else begin
            if (!position_q[0]) position_d = position_q >> 1;
        end
        if (|(position_d & winZone)) begin
            hold_d = (hold_q == 5'd31) ? hold_q : hold_q + 5'd1;
        end else begin
            hold_d = 5'd0;
        end
    end

    // BCD countdown with borrow, holding at 000; plus preset digit clamping.
    always_comb begin
        timeDec_d = timeLeft_q;
        if (timeLeft_q != 12'h000) begin
            if (timeLeft_q[3:0] != 4'd0) begin
                timeDec_d[3:0] = timeLeft_q[3:0] - 4'd1;
            end else begin
                timeDec_d[3:0] = 4'd9;
                if (timeLeft_q[7:4] != 4'd0) begin
                    timeDec_d[7:4] = timeLeft_q[7:4] - 4'd1;
                end else begin
                    timeDec_d[7:4]  = 4'd9;
                    timeDec_d[11:8] = timeLeft_q[11:8] - 4'd1;
                end
            end
        end
        timeLoad_d[3:0]  = (reelTime[3:0]  > 4'd9) ? 4'd9 : reelTime[3:0];
        timeLoad_d[7:4]  = (reelTime[7:4]  > 4'd9) ? 4'd9 : reelTime[7:4];
        timeLoad_d[11:8] = (reelTime[11:8] > 4'd9) ? 4'd9 : reelTime[11:8];
    end

    // End-of-attempt conditions, all evaluated on registered state.
    always_comb begin
        boundHit = |(position_q & (leftLoseBound | rightLoseBound));
        holdMet  = (hold_q >= HOLD_LIMIT);
        timedOut = (timeLeft_q == 12'h000);
    end

    // Attempt state machine with registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            position_q <= '0;
            timeLeft_q <= '0;
            hold_q     <= '0;
            busy_q     <= 1'b0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_REEL: begin
                    // Checks take priority over motion: a firing check freezes
                    // position and time in the same cycle.
                    if (boundHit) begin
                        state_q <= S_LOST;
                        busy_q  <= 1'b0;
                        lose_q  <= 1'b1;
                        done_q  <= 1'b1;
                    end else if (holdMet) begin
                        state_q <= S_WON;
                        busy_q  <= 1'b0;
                        win_q   <= 1'b1;
                        done_q  <= 1'b1;
                    end else if (timedOut) begin
                        state_q <= S_LOST;
                        busy_q  <= 1'b0;
                        lose_q  <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        if (stepTick) begin
                            position_q <= position_d;
                            hold_q     <= hold_d;
                        end
                        if (timeTick) begin
                            timeLeft_q <= timeDec_d;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state_q    <= S_REEL;
                        position_q <= START_ONEHOT;
                        timeLeft_q <= timeLoad_d;
                        hold_q     <= '0;
                        busy_q     <= 1'b1;
                        win_q      <= 1'b0;
                        lose_q     <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign position = position_q;
    assign timeLeft = timeLeft_q;
    assign busy     = busy_q;
    assign win      = win_q;
    assign lose     = lose_q;
    assign done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_reel_controller.sv
//------------------------------------------------------------------------------
// Module      : tb_reel_controller
// Description : Self-checking bench for reel_controller. Directed scenarios
//               plus randomized episodes compared against an integer-level
//               behavioural model of the reel game.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_reel_controller;

    localparam int HOLD_STEPS = 8;
    localparam int START_POS  = 12;

    logic        CLK = 1'b0;
    logic        RST, start, pull, stepTick, timeTick;
    logic [11:0] reelTime;
    logic [25:0] leftLoseBound, rightLoseBound, winZone;
    logic [25:0] position;
    logic [11:0] timeLeft;
    logic        busy, win, lose, done;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: indicator as a bit index, time as a plain integer.
    int m_idx, m_time, m_hold;
    bit m_busy, m_win, m_lose, m_done;

    reel_controller #(.HOLD_STEPS(HOLD_STEPS), .START_POS(START_POS)) dut (
        .CLK(CLK), .RST(RST), .start(start), .pull(pull),
        .stepTick(stepTick), .timeTick(timeTick), .reelTime(reelTime),
        .leftLoseBound(leftLoseBound), .rightLoseBound(rightLoseBound),
        .winZone(winZone), .position(position), .timeLeft(timeLeft),
        .busy(busy), .win(win), .lose(lose), .done(done)
    );

    always #5 CLK = ~CLK;

    function automatic int preset_value(input logic [11:0] b);
        int d2, d1, d0;
        d2 = (b[11:8] > 9) ? 9 : int'(b[11:8]);
        d1 = (b[7:4]  > 9) ? 9 : int'(b[7:4]);
        d0 = (b[3:0]  > 9) ? 9 : int'(b[3:0]);
        return d2 * 100 + d1 * 10 + d0;
    endfunction

    function automatic logic [41:0] model_vec();
        logic [25:0] p;
        logic [11:0] t;
        p = (m_idx < 0) ? 26'd0 : (26'd1 << m_idx);
        t = {4'(m_time / 100), 4'((m_time / 10) % 10), 4'(m_time % 10)};
        return {p, t, m_busy, m_win, m_lose, m_done};
    endfunction

    function automatic logic [41:0] dut_vec();
        return {position, timeLeft, busy, win, lose, done};
    endfunction

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        logic [25:0] lm;
        lm = leftLoseBound | rightLoseBound;
        m_done = 1'b0;
        if (RST) begin
            m_idx = -1; m_time = 0; m_hold = 0;
            m_busy = 0; m_win = 0; m_lose = 0;
        end else if (!m_busy) begin
            if (start) begin
                m_idx = START_POS; m_time = preset_value(reelTime); m_hold = 0;
                m_busy = 1; m_win = 0; m_lose = 0;
            end
        end else if (lm[m_idx]) begin
            m_busy = 0; m_lose = 1; m_done = 1;
        end else if (m_hold >= HOLD_STEPS) begin
            m_busy = 0; m_win = 1; m_done = 1;
        end else if (m_time == 0) begin
            m_busy = 0; m_lose = 1; m_done = 1;
        end else begin
            if (stepTick) begin
                m_idx  = pull ? ((m_idx < 25) ? m_idx + 1 : 25) : ((m_idx > 0) ? m_idx - 1 : 0);
                m_hold = winZone[m_idx] ? m_hold + 1 : 0;
            end
            if (timeTick && m_time > 0) m_time = m_time - 1;
        end
    endtask

    task automatic tick(input logic s, input logic p, input logic st, input logic tt);
        start = s; pull = p; stepTick = st; timeTick = tt;
        @(posedge CLK);
        model_step();
        #1;
        start = 1'b0; stepTick = 1'b0; timeTick = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (dut_vec() !== 42'd0) begin
            failures++;
            $display("FAIL reset_state got %h want %h", dut_vec(), 42'd0);
        end
    endtask

    task automatic test_win();
        int pulls[8] = '{1, 1, 1, 0, 1, 0, 1, 0};
        reelTime = 12'h050; winZone = 26'h000E000;
        leftLoseBound = 26'h3F00000; rightLoseBound = 26'h000001F;
        do_reset();
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({position, timeLeft, busy} !== {26'h0001000, 12'h050, 1'b1}) begin
            failures++;
            $display("FAIL win_load got %h/%h/%b want 0001000/050/1", position, timeLeft, busy);
        end
        foreach (pulls[i]) begin
            tick(1'b0, pulls[i][0], 1'b1, 1'b0);
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++;
                $display("FAIL win_step%0d got %h want %h", i, dut_vec(), model_vec());
            end
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({busy, win, lose, done} !== 4'b0101) begin
            failures++;
            $display("FAIL win_end got busy/win/lose/done=%b want 0101", {busy, win, lose, done});
        end
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({position, win, done} !== {26'h0004000, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL win_hold got pos=%h win=%b done=%b want 0004000/1/0", position, win, done);
        end
    endtask

    task automatic test_timeout();
        reelTime = 12'h003; winZone = '0; leftLoseBound = '0; rightLoseBound = '0;
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b1);
            checks++;
            if ({timeLeft, busy} !== {12'(2 - i), 1'b1}) begin
                failures++;
                $display("FAIL timeout_count%0d got %h busy=%b want %h busy=1", i, timeLeft, busy, 12'(2 - i));
            end
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({busy, win, lose, done} !== 4'b0011) begin
            failures++;
            $display("FAIL timeout_end got %b want 0011", {busy, win, lose, done});
        end
    endtask

    task automatic test_right_bound();
        reelTime = 12'h999; winZone = '0; leftLoseBound = '0; rightLoseBound = 26'h0000010;
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({position, busy, done} !== {26'h0000010, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL bound_pos got %h busy=%b done=%b want 0000010/1/0", position, busy, done);
        end
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({position, timeLeft, busy, lose, done} !== {26'h0000010, 12'h999, 3'b011}) begin
            failures++;
            $display("FAIL bound_lost got %h %h %b want 0000010 999 011", position, timeLeft, {busy, lose, done});
        end
    endtask

    task automatic test_coincide();
        int pulls[8] = '{0, 1, 0, 1, 0, 1, 1, 1};
        reelTime = 12'h500; winZone = 26'h0007800; leftLoseBound = 26'h0004000; rightLoseBound = '0;
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        foreach (pulls[i]) tick(1'b0, pulls[i][0], 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({busy, win, lose, done} !== 4'b0011) begin
            failures++;
            $display("FAIL coincide got %b want 0011", {busy, win, lose, done});
        end
    endtask

    task automatic test_clamp();
        winZone = '0; leftLoseBound = '0; rightLoseBound = '0;
        reelTime = 12'h0A5;
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (timeLeft !== 12'h095) begin
            failures++;
            $display("FAIL clamp_0A5 got %h want 095", timeLeft);
        end
        reelTime = 12'hFCB;
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (timeLeft !== 12'h999) begin
            failures++;
            $display("FAIL clamp_FCB got %h want 999", timeLeft);
        end
    endtask

    task automatic test_midreel();
        reelTime = 12'h200; winZone = '0; leftLoseBound = '0; rightLoseBound = '0;
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({position, timeLeft, busy} !== {26'h0004000, 12'h199, 1'b1}) begin
            failures++;
            $display("FAIL midreel_start got %h %h %b want 0004000 199 1", position, timeLeft, busy);
        end
        RST = 1'b1;
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        RST = 1'b0;
        checks++;
        if (dut_vec() !== 42'd0) begin
            failures++;
            $display("FAIL midreel_rst got %h want 0", dut_vec());
        end
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (dut_vec() !== 42'd0) begin
            failures++;
            $display("FAIL midreel_after got %h want 0", dut_vec());
        end
    endtask

    task automatic test_saturation();
        reelTime = 12'h999; winZone = '0; leftLoseBound = '0; rightLoseBound = '0;
        do_reset();
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) tick(1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({position, busy} !== {26'h2000000, 1'b1}) begin
            failures++;
            $display("FAIL sat_msb got %h busy=%b want 2000000 1", position, busy);
        end
        for (int i = 0; i < 27; i++) tick(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (position !== 26'h0000001) begin
            failures++;
            $display("FAIL sat_lsb got %h want 0000001", position);
        end
    endtask

    task automatic test_random();
        int lo, width;
        for (int ep = 0; ep < 40; ep++) begin
            reelTime = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 11)), 4'($urandom_range(0, 15))};
            lo = $urandom_range(6, 18);
            width = $urandom_range(1, 5);
            winZone = ((26'd1 << width) - 26'd1) << lo;
            leftLoseBound  = ($urandom_range(0, 3) == 0) ? 26'd0 : (26'h3FFFFFF << $urandom_range(17, 25));
            rightLoseBound = ($urandom_range(0, 3) == 0) ? 26'd0 : (26'h3FFFFFF >> $urandom_range(17, 25));
            for (int c = 0; c < 50; c++) begin
                RST = ($urandom_range(0, 99) == 0);
                tick($urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
                RST = 1'b0;
                checks++;
                if (dut_vec() !== model_vec()) begin
                    failures++;
                    $display("FAIL rand_ep%0d_c%0d got %h want %h", ep, c, dut_vec(), model_vec());
                end
            end
        end
    endtask

    initial begin
        RST = 1'b1; start = 1'b0; pull = 1'b0; stepTick = 1'b0; timeTick = 1'b0;
        reelTime = '0; leftLoseBound = '0; rightLoseBound = '0; winZone = '0;
        m_idx = -1; m_time = 0; m_hold = 0;
        m_busy = 0; m_win = 0; m_lose = 0; m_done = 0;
        test_reset();
        test_win();
        test_timeout();
        test_right_bound();
        test_coincide();
        test_clamp();
        test_midreel();
        test_saturation();
        do_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
